// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared decoder constants: load/store size encodings (funct3)
package decoder_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

endpackage

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load-store unit types
package lsu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/half of a memory word and extends it
module lsu_load_align
  import decoder_pkg::*;
(
  input  logic [31:0] mem_rd_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  output logic [31:0] rd_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select by shifting the addressed byte down to bit 0.
  assign shifted = mem_rd_i >> {off_i, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = off_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

  always_comb begin
    rd_o = 32'd0;
    case (size_i)
      LDST_B:  rd_o = {{24{byte_v[7]}}, byte_v};
      LDST_BU: rd_o = {24'd0, byte_v};
      LDST_H:  rd_o = {{16{half_v[15]}}, half_v};
      LDST_HU: rd_o = {16'd0, half_v};
      LDST_W:  rd_o = mem_rd_i;
      default: rd_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load-store unit: core requests to word-addressed memory with byte enables
module lsu
  import decoder_pkg::*;
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t  state_q, state_d;
  logic [1:0]  off;
  logic        is_b, is_h, is_w;
  logic        misalign;
  logic        go;
  logic [31:0] aligned_rd;

  assign off = core_addr_i[1:0];

  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    is_w = 1'b0;
    case (core_size_i)
      LDST_B, LDST_BU: is_b = 1'b1;
      LDST_H, LDST_HU: is_h = 1'b1;
      LDST_W:          is_w = 1'b1;
      default:         ;
    endcase
  end

  assign misalign = core_req_i & ((is_h & off[0]) | (is_w & (off != 2'b00)) | ~(is_b | is_h | is_w));
  assign go       = core_req_i & ~misalign;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A dropped request in WAIT (core flush) abandons the access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (go) state_d = WAIT;
      WAIT: if (mem_ready_i || !go) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lsu_load_align u_load_align (
    .mem_rd_i (mem_rd_i),
    .size_i   (core_size_i),
    .off_i    (off),
    .rd_o     (aligned_rd)
  );

  always_comb begin
    core_misalign_o = misalign;
    core_stall_o    = go & ~((state_q == WAIT) & mem_ready_i);
    mem_req_o       = go;
    mem_we_o        = go & core_we_i;
    mem_addr_o      = core_addr_i;
    mem_be_o        = 4'b0000;
    mem_wd_o        = 32'd0;
    core_rd_o       = 32'd0;
    if (go) begin
      if (is_b) begin
        mem_be_o = 4'b0001 << off;
        mem_wd_o = {4{core_wd_i[7:0]}};
      end else if (is_h) begin
        mem_be_o = off[1] ? 4'b1100 : 4'b0011;
        mem_wd_o = {2{core_wd_i[15:0]}};
      end else begin
        mem_be_o = 4'b1111;
        mem_wd_o = core_wd_i;
      end
      if (!core_we_i) core_rd_o = aligned_rd;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - bench for lsu: byte-level memory model, per-cycle compare, directed vectors
module tb_lsu;
  import decoder_pkg::*;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [2:0]  core_size = 3'd0;
  logic [31:0] core_addr = 32'd0;
  logic [31:0] core_wd = 32'd0;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd = 32'd0;
  logic        mem_ready = 1'b1;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .core_req_i      (core_req),
    .core_we_i       (core_we),
    .core_size_i     (core_size),
    .core_addr_i     (core_addr),
    .core_wd_i       (core_wd),
    .core_rd_o       (core_rd_o),
    .core_stall_o    (core_stall_o),
    .core_misalign_o (core_misalign_o),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_be_o        (mem_be_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wd_o        (mem_wd_o),
    .mem_rd_i        (mem_rd),
    .mem_ready_i     (mem_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory seen by the DUT: word array, registered read.
  logic [31:0] words [0:255];
  initial for (int i = 0; i < 256; i++) words[i] = 32'd0;
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o)
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) words[mem_addr_o[9:2]][8*b +: 8] <= mem_wd_o[8*b +: 8];
      mem_rd <= words[mem_addr_o[9:2]];
    end
  end

  // Reference model: byte-addressed memory updated at core-level store completion.
  logic [7:0]  mdl [0:1023];
  initial for (int i = 0; i < 1024; i++) mdl[i] = 8'd0;

  int          c_n, c_off;
  logic        c_legal, c_mis, c_go;
  logic [3:0]  e_be;
  logic [31:0] e_wd, e_rd;

  always @(negedge clk) begin
    c_legal = !(core_size == 3'd3 || core_size >= 3'd6);
    c_n     = 1 << core_size[1:0];
    c_off   = int'(core_addr[1:0]);
    c_mis   = core_req && (!c_legal || (core_addr % c_n) != 0);
    c_go    = core_req && !c_mis;
    e_be    = c_go ? 4'(((1 << c_n) - 1) << c_off) : 4'd0;
    e_wd    = 32'd0;
    if (c_go) for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = core_wd[8*(i % c_n) +: 8];
    chk("misalign", 32'(core_misalign_o), 32'(c_mis));
    chk("mem_req", 32'(mem_req_o), 32'(c_go));
    chk("mem_we", 32'(mem_we_o), 32'(c_go && core_we));
    chk("mem_be", 32'(mem_be_o), 32'(e_be));
    chk("mem_wd", mem_wd_o, e_wd);
    chk("mem_addr", mem_addr_o, core_addr);
    if (!c_go) begin
      chk("stall_idle", 32'(core_stall_o), 32'd0);
      chk("rd_idle", core_rd_o, 32'd0);
    end else if (core_we) begin
      chk("rd_store", core_rd_o, 32'd0);
      if (!core_stall_o)
        for (int i = 0; i < c_n; i++) mdl[(int'(core_addr[9:0]) + i) & 1023] = core_wd[8*i +: 8];
    end else if (!core_stall_o) begin
      e_rd = 32'd0;
      for (int i = 0; i < c_n; i++) e_rd[8*i +: 8] = mdl[(int'(core_addr[9:0]) + i) & 1023];
      if (!core_size[2] && c_n < 4 && e_rd[8*c_n-1]) e_rd = e_rd | (32'hFFFF_FFFF << (8*c_n));
      chk("rd_release", core_rd_o, e_rd);
    end
  end

  // One complete access; call at posedge+1. Ready low for the request cycle plus `waits` cycles.
  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits,
                        output int stalls, output int reqs, output logic [31:0] rd,
                        output logic [3:0] be, output logic [31:0] mwd, output logic mis);
    logic done;
    core_req = 1'b1; core_we = we; core_size = sz; core_addr = addr; core_wd = wd;
    stalls = 0; reqs = 0; rd = 32'd0; be = 4'd0; mwd = 32'd0; mis = 1'b0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      mem_ready = (waits == 0) || (c > waits);
      @(negedge clk);
      if (c == 0) begin be = mem_be_o; mwd = mem_wd_o; mis = core_misalign_o; end
      if (mem_req_o) reqs++;
      rd = core_rd_o;
      if (!core_stall_o) done = 1'b1;
      else stalls++;
      @(posedge clk); #1;
    end
    chk("access_done", 32'(done), 32'd1);
    core_req = 1'b0; core_we = 1'b0; core_size = 3'd0; core_addr = 32'd0; core_wd = 32'd0;
    mem_ready = 1'b1;
  endtask

  int          st, rq;
  logic [31:0] rd, mwd;
  logic [3:0]  be;
  logic        mis;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;

    access(1'b1, LDST_W, 32'h0000_0104, 32'hDEAD_BEEF, 0, st, rq, rd, be, mwd, mis);
    chk("sw_be", 32'(be), 32'h0000_000F);
    chk("sw_wd", mwd, 32'hDEAD_BEEF);
    chk("sw_stalls", st, 1);
    chk("sw_reqs", rq, 2);
    access(1'b0, LDST_W, 32'h0000_0104, 32'd0, 0, st, rq, rd, be, mwd, mis);
    chk("lw_rd", rd, 32'hDEAD_BEEF);
    chk("lw_stalls", st, 1);

    access(1'b1, LDST_B, 32'h0000_0107, 32'h0000_00A5, 0, st, rq, rd, be, mwd, mis);
    chk("sb_be", 32'(be), 32'h0000_0008);
    chk("sb_wd", mwd, 32'hA5A5_A5A5);
    access(1'b0, LDST_B, 32'h0000_0107, 32'd0, 0, st, rq, rd, be, mwd, mis);
    chk("lb_rd", rd, 32'hFFFF_FFA5);
    access(1'b0, LDST_BU, 32'h0000_0107, 32'd0, 0, st, rq, rd, be, mwd, mis);
    chk("lbu_rd", rd, 32'h0000_00A5);
    access(1'b0, LDST_W, 32'h0000_0104, 32'd0, 0, st, rq, rd, be, mwd, mis);
    chk("lw_after_sb", rd, 32'hA5AD_BEEF);

    access(1'b1, LDST_H, 32'h0000_010A, 32'h0000_8001, 0, st, rq, rd, be, mwd, mis);
    chk("sh_be", 32'(be), 32'h0000_000C);
    chk("sh_wd", mwd, 32'h8001_8001);
    access(1'b0, LDST_H, 32'h0000_010A, 32'd0, 0, st, rq, rd, be, mwd, mis);
    chk("lh_rd", rd, 32'hFFFF_8001);
    access(1'b0, LDST_HU, 32'h0000_010A, 32'd0, 0, st, rq, rd, be, mwd, mis);
    chk("lhu_rd", rd, 32'h0000_8001);

    access(1'b1, LDST_H, 32'h0000_0100, 32'h1234_7FFE, 0, st, rq, rd, be, mwd, mis);
    chk("sh_lo_be", 32'(be), 32'h0000_0003);
    access(1'b0, LDST_H, 32'h0000_0100, 32'd0, 0, st, rq, rd, be, mwd, mis);
    chk("lh_pos_rd", rd, 32'h0000_7FFE);
    access(1'b0, LDST_B, 32'h0000_0101, 32'd0, 0, st, rq, rd, be, mwd, mis);
    chk("lb_pos_rd", rd, 32'h0000_007F);

    access(1'b0, LDST_H, 32'h0000_0103, 32'd0, 0, st, rq, rd, be, mwd, mis);
    chk("lh_mis_flag", 32'(mis), 32'd1);
    chk("lh_mis_stalls", st, 0);
    chk("lh_mis_reqs", rq, 0);
    chk("lh_mis_state", 32'(dut.state_q), 32'(IDLE));
    access(1'b0, LDST_W, 32'h0000_0102, 32'd0, 0, st, rq, rd, be, mwd, mis);
    chk("lw_mis_flag", 32'(mis), 32'd1);
    chk("lw_mis_stalls", st, 0);
    chk("lw_mis_state", 32'(dut.state_q), 32'(IDLE));
    access(1'b0, 3'd3, 32'h0000_0100, 32'd0, 0, st, rq, rd, be, mwd, mis);
    chk("illegal_flag", 32'(mis), 32'd1);

    access(1'b0, LDST_W, 32'h0000_0104, 32'd0, 3, st, rq, rd, be, mwd, mis);
    chk("slow_stalls", st, 4);
    chk("slow_rd", rd, 32'hA5AD_BEEF);

    // Core flush: request dropped while waiting on memory.
    core_req = 1'b1; core_size = LDST_W; core_addr = 32'h0000_0108; mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("flush_in_wait", 32'(dut.state_q), 32'(WAIT));
    core_req = 1'b0; core_addr = 32'd0;
    @(negedge clk);
    chk("flush_stall", 32'(core_stall_o), 32'd0);
    @(posedge clk); #1;
    chk("flush_state", 32'(dut.state_q), 32'(IDLE));
    mem_ready = 1'b1;

    // Reset mid-access.
    core_req = 1'b1; core_size = LDST_W; core_addr = 32'h0000_0104; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; core_req = 1'b0; core_addr = 32'd0; core_size = 3'd0;
    @(negedge clk);
    chk("rst_outputs", {core_rd_o[29:0], core_stall_o, core_misalign_o}, 32'd0);
    @(posedge clk); #1;
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0; mem_ready = 1'b1;
    access(1'b0, LDST_BU, 32'h0000_010B, 32'd0, 0, st, rq, rd, be, mwd, mis);
    chk("post_rst_stalls", st, 1);
    chk("post_rst_rd", rd, 32'h0000_0080);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
